// File: rtl/qed_pkg.sv
// Shared constants and FSM state type for the QED consistency checker.
package qed_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  localparam int ORIG_REGS  = 15;
  localparam int DUP_OFFSET = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } qed_state_e;

endpackage

// File: rtl/qed_commit_classify.sv
// Decides whether a retired instruction belongs to the original (x1..x15)
// or duplicate (x16..x31) stream of a QED-transformed program.
module qed_commit_classify
  import qed_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_orig,
  output logic        is_dup
);

  logic [6:0] opcode;
  logic [4:0] key;
  logic       known_op;
  logic       unused_ok;

  assign opcode = instr[6:0];

  // Stores write no register, so the base register identifies the stream.
  assign key = (opcode == OP_SW) ? instr[19:15] : instr[11:7];

  assign known_op = (opcode == OP_R) || (opcode == OP_I) ||
                    (opcode == OP_LW) || (opcode == OP_SW);

  assign is_orig = known_op && (key != 5'd0) && !key[4];
  assign is_dup  = known_op && key[4];

  assign unused_ok = ^{instr[31:20], instr[14:12]};

endmodule

// File: rtl/qed_consistency_checker.sv
// Counts original/duplicate commits and sweeps the register file pairwise
// (xi vs xi+16) when the streams balance. Build with QED_STICKY_ERROR_EN to
// keep qed_error/mismatch_idx until reset instead of clearing per sweep.
module qed_consistency_checker
  import qed_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit_valid,
  input  logic [31:0]      commit_instruction,
  input  logic             check_en,
  output logic [4:0]       rf_addr_a,
  output logic [4:0]       rf_addr_b,
  input  logic [31:0]      rf_data_a,
  input  logic [31:0]      rf_data_b,
  output logic [CNT_W-1:0] num_orig,
  output logic [CNT_W-1:0] num_dup,
  output logic             qed_ready,
  output logic             qed_done,
  output logic             qed_error,
  output logic             cnt_ovf,
  output logic [3:0]       mismatch_idx
);

  // state    | meaning
  // ST_IDLE  | counting commits, waiting for balance + check_en
  // ST_SWEEP | issuing read pairs i / i+16 for i = 1..15
  // ST_DRAIN | comparing the data of the last pair
  // ST_DONE  | sweep finished, qed_done high until a counted commit

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [4:0]       LAST_IDX = 5'(ORIG_REGS);
  localparam logic [4:0]       DUP_OFS  = 5'(DUP_OFFSET);

  logic is_orig, is_dup;
  logic commit_orig, commit_dup, counted;

  qed_commit_classify u_classify (
    .instr   (commit_instruction),
    .is_orig (is_orig),
    .is_dup  (is_dup)
  );

  assign commit_orig = commit_valid && is_orig;
  assign commit_dup  = commit_valid && is_dup;
  assign counted     = commit_orig || commit_dup;

  qed_state_e       state_q, state_d;
  logic [CNT_W-1:0] num_orig_q, num_orig_d;
  logic [CNT_W-1:0] num_dup_q, num_dup_d;
  logic             cnt_ovf_q, cnt_ovf_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [3:0]       idx_q, idx_d;
  logic [4:0]       addr_a_q, addr_a_d;
  logic [4:0]       addr_b_q, addr_b_d;
  logic             prev_vld_q, prev_vld_d;
  logic [3:0]       prev_idx_q, prev_idx_d;

  always_comb begin
    state_d    = state_q;
    num_orig_d = num_orig_q;
    num_dup_d  = num_dup_q;
    cnt_ovf_d  = cnt_ovf_q;
    err_d      = err_q;
    idx_d      = idx_q;
    addr_a_d   = 5'd0;
    addr_b_d   = 5'd0;
    prev_vld_d = (state_q == ST_SWEEP);
    prev_idx_d = addr_a_q[3:0];

    if (commit_orig) begin
      if (num_orig_q == CNT_MAX) cnt_ovf_d = 1'b1;
      else                       num_orig_d = num_orig_q + CNT_W'(1);
    end
    if (commit_dup) begin
      if (num_dup_q == CNT_MAX) cnt_ovf_d = 1'b1;
      else                      num_dup_d = num_dup_q + CNT_W'(1);
    end

    // Ready reflects the counts being written this cycle, so a sweep can
    // only start on a later, commit-free cycle.
    ready_d = (num_orig_d == num_dup_d) && (num_orig_d != '0) && !cnt_ovf_d;

    case (state_q)
      ST_IDLE: begin
        if (ready_q && check_en && !counted) begin
          state_d  = ST_SWEEP;
          addr_a_d = 5'd1;
          addr_b_d = 5'd1 + DUP_OFS;
`ifndef QED_STICKY_ERROR_EN
          err_d    = 1'b0;
          idx_d    = 4'd0;
`endif
        end
      end
      ST_SWEEP: begin
        if (counted) begin
          state_d = ST_IDLE;
        end else if (addr_a_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          addr_a_d = addr_a_q + 5'd1;
          addr_b_d = addr_a_q + 5'd1 + DUP_OFS;
        end
      end
      ST_DRAIN: state_d = counted ? ST_IDLE : ST_DONE;
      ST_DONE:  if (counted) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if ((state_q == ST_SWEEP || state_q == ST_DRAIN) && prev_vld_q && !counted &&
        (rf_data_a != rf_data_b) && !err_q) begin
      err_d = 1'b1;
      idx_d = prev_idx_q;
    end

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      num_orig_q <= '0;
      num_dup_q  <= '0;
      cnt_ovf_q  <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= 4'd0;
      addr_a_q   <= 5'd0;
      addr_b_q   <= 5'd0;
      prev_vld_q <= 1'b0;
      prev_idx_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      num_orig_q <= num_orig_d;
      num_dup_q  <= num_dup_d;
      cnt_ovf_q  <= cnt_ovf_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      prev_vld_q <= prev_vld_d;
      prev_idx_q <= prev_idx_d;
    end
  end

  assign rf_addr_a    = addr_a_q;
  assign rf_addr_b    = addr_b_q;
  assign num_orig     = num_orig_q;
  assign num_dup      = num_dup_q;
  assign qed_ready    = ready_q;
  assign qed_done     = done_q;
  assign qed_error    = err_q;
  assign cnt_ovf      = cnt_ovf_q;
  assign mismatch_idx = idx_q;

endmodule

// File: tb/tb_qed_consistency_checker.sv
// Randomized self-checking bench for qed_consistency_checker against a
// behavioural commit-count / register-pair model.
module tb_qed_consistency_checker;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LW_OP  = 7'b0000011;
  localparam logic [6:0] SW_OP  = 7'b0100011;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] JAL_OP = 7'b1101111;

  logic        clk, rst_n, commit_valid, check_en;
  logic [31:0] commit_instruction, rf_data_a, rf_data_b;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [15:0] num_orig, num_dup;
  logic        qed_ready, qed_done, qed_error, cnt_ovf;
  logic [3:0]  mismatch_idx;

  logic        c2_valid;
  logic [31:0] c2_instr;
  logic [4:0]  c2_addr_a, c2_addr_b;
  logic [1:0]  c2_orig, c2_dup;
  logic        c2_ready, c2_done, c2_err, c2_ovf;
  logic [3:0]  c2_idx;

  qed_consistency_checker dut (
    .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid),
    .commit_instruction(commit_instruction), .check_en(check_en),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .num_orig(num_orig), .num_dup(num_dup), .qed_ready(qed_ready),
    .qed_done(qed_done), .qed_error(qed_error), .cnt_ovf(cnt_ovf),
    .mismatch_idx(mismatch_idx)
  );

  qed_consistency_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .commit_valid(c2_valid),
    .commit_instruction(c2_instr), .check_en(check_en),
    .rf_addr_a(c2_addr_a), .rf_addr_b(c2_addr_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .num_orig(c2_orig), .num_dup(c2_dup), .qed_ready(c2_ready),
    .qed_done(c2_done), .qed_error(c2_err), .cnt_ovf(c2_ovf),
    .mismatch_idx(c2_idx)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_orig, m_dup;
  bit m_ovf, m_err;
  int m_idx;
  logic [31:0] rf_mem [32];
  logic [4:0]  pa, pb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file model: data for an address appears one cycle later
  always @(negedge clk) begin
    rf_data_a = rf_mem[pa];
    rf_data_b = rf_mem[pb];
    pa = rf_addr_a;
    pb = rf_addr_b;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] key);
    logic [31:0] w;
    w = $urandom;
    w[6:0] = op;
    if (op == SW_OP) w[19:15] = key;
    else             w[11:7]  = key;
    return w;
  endfunction

  // 0 = ignored, 1 = original, 2 = duplicate
  function automatic int classify_ref(input logic [31:0] ins);
    int key;
    if (ins[6:0] == SW_OP) key = int'(ins[19:15]);
    else if (ins[6:0] == R_OP || ins[6:0] == I_OP || ins[6:0] == LW_OP) key = int'(ins[11:7]);
    else return 0;
    if (key == 0) return 0;
    return (key >= 16) ? 2 : 1;
  endfunction

  function automatic bit exp_ready();
    return (m_orig == m_dup) && (m_orig != 0) && !m_ovf;
  endfunction

  task automatic do_commit(input logic [31:0] ins);
    int k;
    commit_valid = 1'b1;
    commit_instruction = ins;
    k = classify_ref(ins);
    if (k == 1) begin if (m_orig == 65535) m_ovf = 1; else m_orig++; end
    if (k == 2) begin if (m_dup == 65535) m_ovf = 1; else m_dup++; end
    @(negedge clk);
    commit_valid = 1'b0;
    commit_instruction = $urandom;
  endtask

  task automatic do_commit2(input logic [31:0] ins);
    c2_valid = 1'b1;
    c2_instr = ins;
    @(negedge clk);
    c2_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_orig = 0; m_dup = 0; m_ovf = 0; m_err = 0; m_idx = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_num_orig"}, 32'(num_orig), 0);
    check({tag, "_num_dup"}, 32'(num_dup), 0);
    check({tag, "_ready"}, 32'(qed_ready), 0);
    check({tag, "_done"}, 32'(qed_done), 0);
    check({tag, "_error"}, 32'(qed_error), 0);
    check({tag, "_ovf"}, 32'(cnt_ovf), 0);
    check({tag, "_idx"}, 32'(mismatch_idx), 0);
    check({tag, "_addr_a"}, 32'(rf_addr_a), 0);
    check({tag, "_addr_b"}, 32'(rf_addr_b), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_num_orig"}, 32'(num_orig), 32'(m_orig));
    check({tag, "_num_dup"}, 32'(num_dup), 32'(m_dup));
    check({tag, "_ready"}, 32'(qed_ready), 32'(exp_ready()));
  endtask

  task automatic run_sweep(input string tag);
    int waitc;
    int found;
    check_en = 1'b1;
    waitc = 0;
    while (rf_addr_a == 5'd0 && waitc < 4) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, "_start"}, 32'(rf_addr_a != 5'd0), 1);
    for (int k = 1; k <= 15; k++) begin
      check({tag, "_addr_a"}, 32'(rf_addr_a), 32'(k));
      check({tag, "_addr_b"}, 32'(rf_addr_b), 32'(k + 16));
      check({tag, "_early_done"}, 32'(qed_done), 0);
      @(negedge clk);
    end
    check({tag, "_drain_addr"}, 32'(rf_addr_a), 0);
    check({tag, "_drain_done"}, 32'(qed_done), 0);
    @(negedge clk);
    check({tag, "_done_lat17"}, 32'(qed_done), 1);
    check_en = 1'b0;
    found = 0;
    for (int i = 15; i >= 1; i--)
      if (rf_mem[i] != rf_mem[i + 16]) found = i;
`ifdef QED_STICKY_ERROR_EN
    if (!m_err && found != 0) begin m_err = 1; m_idx = found; end
`else
    m_err = (found != 0);
    m_idx = found;
`endif
    check({tag, "_error"}, 32'(qed_error), 32'(m_err));
    check({tag, "_idx"}, 32'(mismatch_idx), 32'(m_idx));
  endtask

  task automatic clean_rf();
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = $urandom;
      rf_mem[i + 16] = rf_mem[i];
    end
  endtask

  initial begin
    int seen;
    int waitc;
    rst_n = 1'b0;
    commit_valid = 1'b0;
    commit_instruction = 32'd0;
    check_en = 1'b0;
    c2_valid = 1'b0;
    c2_instr = 32'd0;
    pa = 5'd0;
    pb = 5'd0;
    model_reset();
    clean_rf();
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    // clean sweep; check_en already high when the balancing commit lands
    check_en = 1'b1;
    do_commit(mk(I_OP, 5'd3));
    check_counts("addi3");
    do_commit(mk(I_OP, 5'd19));
    check_counts("addi19");
    check("same_cycle_no_sweep", 32'(rf_addr_a), 0);
    run_sweep("clean");
    do_commit(mk(BR_OP, 5'd5));
    check("ignored_keeps_done", 32'(qed_done), 1);
    do_commit(mk(I_OP, 5'd3));
    check("counted_leaves_done", 32'(qed_done), 0);
    do_commit(mk(I_OP, 5'd19));
    check_counts("rebalance");

    // mismatch at x7 / x23
    rf_mem[7] = 32'h5;
    rf_mem[23] = 32'h6;
    run_sweep("mis7");
    check("mis7_idx_abs", 32'(mismatch_idx), 7);

    // new clean sweep after an error
    clean_rf();
    do_commit(mk(R_OP, 5'd9));
    do_commit(mk(LW_OP, 5'd25));
    run_sweep("after_err");

    // abort mid-sweep with an original commit
    do_commit(mk(I_OP, 5'd2));
    do_commit(mk(I_OP, 5'd18));
    check_en = 1'b1;
    waitc = 0;
    while (rf_addr_a != 5'd5 && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    check("abort_reach_i5", 32'(rf_addr_a), 5);
`ifndef QED_STICKY_ERROR_EN
    m_err = 0; m_idx = 0;
`endif
    do_commit(32'h00208233);
    check("abort_idle", 32'(rf_addr_a), 0);
    check_counts("abort");
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (qed_done) seen++;
    end
    check("abort_no_done", 32'(seen), 0);
    check("abort_error", 32'(qed_error), 32'(m_err));
    check("abort_idx", 32'(mismatch_idx), 32'(m_idx));
    check_en = 1'b0;

    // reset asserted mid-sweep
    do_commit(mk(SW_OP, 5'd30));
    check_counts("rebal_dup");
    check_en = 1'b1;
    waitc = 0;
    while (rf_addr_a != 5'd8 && waitc < 12) begin
      @(negedge clk);
      waitc++;
    end
    check("rst_reach_i8", 32'(rf_addr_a), 8);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("midsweep_rst");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (qed_done) seen++;
    end
    check("rst_no_done", 32'(seen), 0);
    check_en = 1'b0;

    // SW x20 dup, rd=x0 NOP, branch ignored
    do_commit(32'h001A2023);
    do_commit(32'h00208033);
    do_commit(32'h00208463);
    check("sw_num_dup", 32'(num_dup), 1);
    check("sw_num_orig", 32'(num_orig), 0);
    check("sw_ready", 32'(qed_ready), 0);

    // randomized commit stream against the counting model
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      logic [6:0] ops [6];
      ops = '{R_OP, I_OP, LW_OP, SW_OP, BR_OP, JAL_OP};
      if ($urandom_range(0, 1) == 1) begin
        do_commit(mk(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 31))));
      end else begin
        commit_instruction = $urandom;
        @(negedge clk);
      end
      check_counts("rand");
    end

    // randomized sweeps with 0..2 injected mismatches
    apply_reset();
    for (int it = 0; it < 4; it++) begin
      logic [6:0] dops [4];
      dops = '{R_OP, I_OP, LW_OP, SW_OP};
      do_commit(mk(dops[$urandom_range(0, 3)], 5'($urandom_range(1, 15))));
      do_commit(mk(dops[$urandom_range(0, 3)], 5'($urandom_range(16, 31))));
      check_counts("rsweep_counts");
      clean_rf();
      repeat ($urandom_range(0, 2)) begin
        int j;
        j = $urandom_range(1, 15);
        rf_mem[j + 16] = rf_mem[j] ^ ($urandom | 32'd1);
      end
      run_sweep("rsweep");
    end

    // CNT_W=2 saturation
    apply_reset();
    repeat (3) do_commit2(mk(R_OP, 5'd1));
    check("sat_orig3", 32'(c2_orig), 3);
    check("sat_no_ovf_yet", 32'(c2_ovf), 0);
    do_commit2(mk(I_OP, 5'd6));
    check("sat_orig_hold", 32'(c2_orig), 3);
    check("sat_ovf", 32'(c2_ovf), 1);
    repeat (3) do_commit2(mk(LW_OP, 5'd17));
    check("sat_dup3", 32'(c2_dup), 3);
    check("sat_ready", 32'(c2_ready), 0);
    check_en = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (c2_addr_a != 5'd0 || c2_done) seen++;
    end
    check("sat_no_sweep", 32'(seen), 0);
    check("sat_ovf_sticky", 32'(c2_ovf), 1);
    check_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
